// File: rtl/tlb_pkg.sv
// tlb_pkg: entry layout, CP0 field positions and FSM codes
// shared by the joint TLB and its match ports.
package tlb_pkg;

  localparam int ENTRYHI_VPN2 = 13;
  localparam int ENTRYHI_ASID = 0;
  localparam int ENTRYLO_PFN = 6;
  localparam int ENTRYLO_C = 3;
  localparam int ENTRYLO_D = 2;
  localparam int ENTRYLO_V = 1;
  localparam int ENTRYLO_G = 0;
  localparam int PROBE_MISS_BIT = 31;
  localparam int PROBE_MULTI_BIT = 30;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0] c;
    logic d;
    logic v;
  } tlb_page_t;

  typedef struct packed {
    logic e;
    logic [11:0] mask;
    logic [18:0] vpn2;
    logic g;
    logic [7:0] asid;
    tlb_page_t p0;
    tlb_page_t p1;
  } tlb_entry_t;

  function automatic tlb_page_t lo_page(
    input logic [25:1] lo,
    input logic [11:0] m
  );
    tlb_page_t p;
    p.pfn = lo[ENTRYLO_PFN +: 20] & ~{8'h00, m};
    p.c = lo[ENTRYLO_C +: 3];
    p.d = lo[ENTRYLO_D];
    p.v = lo[ENTRYLO_V];
    return p;
  endfunction

  function automatic logic [31:0] page_lo(
    input tlb_page_t p,
    input logic g
  );
    return {6'b0, p.pfn, p.c, p.d, p.v, g};
  endfunction

endpackage

// File: rtl/tlb_match_port.sv
// tlb_match_port: combinational match, page select and
// translation of one address against every TLB entry.
module tlb_match_port
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDXBITS = 5
) (
  input  tlb_entry_t         ents [ENTRIES],
  input  logic [31:0]        vaddr,
  input  logic [7:0]         asid,
  input  logic               store,
  output logic               miss,
  output logic               multi,
  output logic [IDXBITS-1:0] idx,
  output logic [31:0]        paddr,
  output logic [2:0]         cache,
  output logic               invalid,
  output logic               modify
);

  logic hit, v, d, m;
  logic [18:0] vmask;
  logic [4:0] sb;
  tlb_page_t pg;

  // Walk high to low so the lowest matching index is kept.
  always_comb begin
    hit = 1'b0;
    multi = 1'b0;
    idx = '0;
    paddr = '0;
    cache = '0;
    v = 1'b0;
    d = 1'b0;
    m = 1'b0;
    vmask = '0;
    sb = '0;
    pg = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      vmask = {7'h00, ents[i].mask};
      m = ents[i].e
        && ((vaddr[31:13] & ~vmask) == (ents[i].vpn2 & ~vmask))
        && (ents[i].g || (ents[i].asid == asid));
      sb = 5'd12;
      for (int j = 0; j < 12; j++)
        if (ents[i].mask[j]) sb = 5'(13 + j);
      pg = vaddr[sb] ? ents[i].p1 : ents[i].p0;
      if (m) begin
        multi = multi | hit;
        hit = 1'b1;
        idx = IDXBITS'(i);
        paddr = paddr
          | ({pg.pfn, 12'h000} & ~{8'h00, ents[i].mask, 12'h000})
          | (vaddr & {8'h00, ents[i].mask, 12'hfff});
        cache = cache | pg.c;
        v = v | pg.v;
        d = d | pg.d;
      end
    end
  end

  assign miss = ~hit;
  assign invalid = hit & ~v;
  assign modify = hit & v & store & ~d;

endmodule

// File: rtl/tlb_pipe.sv
// tlb_pipe: joint TLB with registered lookup channels, probe,
// Random/Wired replacement and an invalidate-all sweep.
module tlb_pipe
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDXBITS = 5,
  parameter int PORTS = 2,
  parameter int ASIDBITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ASIDBITS-1:0] asid,
  input  logic                wr_en,
  input  logic                wr_rand,
  input  logic [IDXBITS-1:0]  wr_idx,
  input  logic [11:0]         mask,
  input  logic [31:0]         entryhi,
  input  logic [31:0]         entrylo0,
  input  logic [31:0]         entrylo1,
  input  logic                wired_we,
  input  logic [IDXBITS-1:0]  wired_in,
  output logic [IDXBITS-1:0]  random,
  output logic [31:0]         rd_hi,
  output logic [31:0]         rd_lo0,
  output logic [31:0]         rd_lo1,
  output logic [11:0]         rd_mask,
  input  logic                probe_req,
  output logic                probe_done,
  output logic [31:0]         probe_index,
  input  logic                flush,
  output logic                busy,
  input  logic [PORTS-1:0]    lk_valid,
  input  logic [PORTS*32-1:0] lk_vaddr,
  input  logic [PORTS-1:0]    lk_store,
  output logic [PORTS-1:0]    res_valid,
  output logic [PORTS*32-1:0] res_paddr,
  output logic [PORTS*3-1:0]  res_cache,
  output logic [PORTS-1:0]    res_miss,
  output logic [PORTS-1:0]    res_invalid,
  output logic [PORTS-1:0]    res_modify
);

  localparam logic [IDXBITS-1:0] TOP = IDXBITS'(ENTRIES - 1);

  tlb_entry_t ents [ENTRIES];
  tlb_entry_t nent, rent;
  logic [0:0] state;
  logic [IDXBITS-1:0] ptr, wired, widx;
  logic [7:0] asid_x, pasid;

  assign asid_x = 8'(asid);
  assign pasid = 8'(entryhi[ENTRYHI_ASID +: ASIDBITS]);
  assign widx = wr_en ? wr_idx : random;
  assign busy = (state == ST_CLEAR);

  always_comb begin
    nent = '0;
    nent.e = 1'b1;
    nent.mask = mask;
    nent.vpn2 = entryhi[31:ENTRYHI_VPN2] & ~{7'h00, mask};
    nent.g = entrylo0[ENTRYLO_G] & entrylo1[ENTRYLO_G];
    nent.asid[ASIDBITS-1:0] = entryhi[ENTRYHI_ASID +: ASIDBITS];
    nent.p0 = lo_page(entrylo0[25:1], mask);
    nent.p1 = lo_page(entrylo1[25:1], mask);
  end

  // The sweep's clear is last, so it beats a write to the same slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) ents[i] <= '0;
      state <= ST_CLEAR;
      ptr <= '0;
    end else begin
      if (wr_en || wr_rand) ents[widx] <= nent;
      unique case (1'b1)
        state == ST_CLEAR: begin
          ents[ptr].e <= 1'b0;
          if (flush) ptr <= '0;
          else if (ptr == TOP) state <= ST_IDLE;
          else ptr <= ptr + IDXBITS'(1);
        end
        default: begin
          if (flush) begin
            state <= ST_CLEAR;
            ptr <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random <= TOP;
      wired <= '0;
    end else begin
      if (wired_we) wired <= wired_in;
      if (wired_we || random <= wired) random <= TOP;
      else random <= random - IDXBITS'(1);
    end
  end

  assign rent = ents[wr_idx];
  assign rd_hi = {rent.vpn2, 5'b0, rent.asid};
  assign rd_lo0 = page_lo(rent.p0, rent.g);
  assign rd_lo1 = page_lo(rent.p1, rent.g);
  assign rd_mask = rent.mask;

  logic p_miss, p_multi, p_iv, p_mo;
  logic [IDXBITS-1:0] p_idx;
  logic [31:0] p_pa, p_word;
  logic [2:0] p_ca;

  tlb_match_port #(.ENTRIES(ENTRIES), .IDXBITS(IDXBITS)) u_probe (
    .ents(ents), .vaddr(entryhi), .asid(pasid), .store(1'b0),
    .miss(p_miss), .multi(p_multi), .idx(p_idx),
    .paddr(p_pa), .cache(p_ca), .invalid(p_iv), .modify(p_mo)
  );

  always_comb begin
    p_word = '0;
    p_word[PROBE_MISS_BIT] = p_miss;
    p_word[PROBE_MULTI_BIT] = p_multi;
    p_word[IDXBITS-1:0] = p_idx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      probe_done <= 1'b0;
      probe_index <= '0;
    end else begin
      probe_done <= probe_req;
      if (probe_req) probe_index <= p_word;
    end
  end

  for (genvar k = 0; k < PORTS; k++) begin : g_lk
    logic mi, iv, mo, mu, v_q, mi_q, iv_q, mo_q;
    logic [IDXBITS-1:0] ix;
    logic [31:0] pa, pa_q;
    logic [2:0] ca, ca_q;
    logic unused_lk;

    tlb_match_port #(.ENTRIES(ENTRIES), .IDXBITS(IDXBITS)) u_match (
      .ents(ents), .vaddr(lk_vaddr[32*k +: 32]), .asid(asid_x),
      .store(lk_store[k]), .miss(mi), .multi(mu), .idx(ix),
      .paddr(pa), .cache(ca), .invalid(iv), .modify(mo)
    );

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v_q <= 1'b0;
        mi_q <= 1'b0;
        iv_q <= 1'b0;
        mo_q <= 1'b0;
        pa_q <= '0;
        ca_q <= '0;
      end else begin
        v_q <= lk_valid[k];
        if (lk_valid[k]) begin
          mi_q <= mi;
          iv_q <= iv;
          mo_q <= mo;
          pa_q <= pa;
          ca_q <= ca;
        end
      end
    end

    assign res_valid[k] = v_q;
    assign res_miss[k] = mi_q;
    assign res_invalid[k] = iv_q;
    assign res_modify[k] = mo_q;
    assign res_paddr[32*k +: 32] = pa_q;
    assign res_cache[3*k +: 3] = ca_q;
    assign unused_lk = ^{mu, ix};
  end

  logic unused_bits;
  assign unused_bits = ^{entrylo0[31:26], entrylo1[31:26],
                         rent.e, p_pa, p_ca, p_iv, p_mo};

endmodule

// File: tb/tb_tlb_pipe.sv
// tb_tlb_pipe: directed vectors for tlb_pipe, checked by a
// scoreboard monitor on res_valid and probe_done.
module tb_tlb_pipe;

  localparam int ENTRIES = 32;
  localparam int IDXBITS = 5;
  localparam int PORTS = 2;
  localparam int ASIDBITS = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [ASIDBITS-1:0] asid;
  logic wr_en, wr_rand, wired_we, probe_req, flush;
  logic [IDXBITS-1:0] wr_idx, wired_in, random;
  logic [11:0] mask, rd_mask;
  logic [31:0] entryhi, entrylo0, entrylo1;
  logic [31:0] rd_hi, rd_lo0, rd_lo1, probe_index;
  logic probe_done, busy;
  logic [PORTS-1:0] lk_valid, lk_store;
  logic [PORTS*32-1:0] lk_vaddr, res_paddr;
  logic [PORTS-1:0] res_valid, res_miss, res_invalid, res_modify;
  logic [PORTS*3-1:0] res_cache;

  tlb_pipe #(
    .ENTRIES(ENTRIES), .IDXBITS(IDXBITS),
    .PORTS(PORTS), .ASIDBITS(ASIDBITS)
  ) dut (
    .clk(clk), .resetn(resetn), .asid(asid),
    .wr_en(wr_en), .wr_rand(wr_rand), .wr_idx(wr_idx),
    .mask(mask), .entryhi(entryhi),
    .entrylo0(entrylo0), .entrylo1(entrylo1),
    .wired_we(wired_we), .wired_in(wired_in), .random(random),
    .rd_hi(rd_hi), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
    .rd_mask(rd_mask), .probe_req(probe_req),
    .probe_done(probe_done), .probe_index(probe_index),
    .flush(flush), .busy(busy), .lk_valid(lk_valid),
    .lk_vaddr(lk_vaddr), .lk_store(lk_store),
    .res_valid(res_valid), .res_paddr(res_paddr),
    .res_cache(res_cache), .res_miss(res_miss),
    .res_invalid(res_invalid), .res_modify(res_modify)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [37:0] q0[$];
  logic [37:0] q1[$];
  logic [31:0] pq[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] ex(input logic mi, input logic iv,
                                     input logic mo,
                                     input logic [2:0] c,
                                     input logic [31:0] pa);
    return {mi, iv, mo, c, pa};
  endfunction

  localparam logic [37:0] MISS = {1'b1, 37'b0};

  function automatic logic [37:0] act(input int k);
    return {res_miss[k], res_invalid[k], res_modify[k],
            res_cache[3*k +: 3], res_paddr[32*k +: 32]};
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (res_valid[0]) begin
        check("lk0 expected", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) check("lk0", 64'(act(0)), 64'(q0.pop_front()));
      end
      if (res_valid[1]) begin
        check("lk1 expected", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) check("lk1", 64'(act(1)), 64'(q1.pop_front()));
      end
      if (probe_done) begin
        check("probe expected", 64'(pq.size() != 0), 64'd1);
        if (pq.size() != 0) check("probe", 64'(probe_index), 64'(pq.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input int ch, input logic [31:0] va,
                      input logic st, input logic [37:0] e);
    lk_valid[ch] = 1'b1;
    lk_vaddr[32*ch +: 32] = va;
    lk_store[ch] = st;
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic go;
    tick;
    lk_valid = '0;
    lk_store = '0;
  endtask

  task automatic tlbwi(input logic [4:0] idx, input logic [31:0] hi,
                       input logic [31:0] l0, input logic [31:0] l1,
                       input logic [11:0] m);
    wr_en = 1'b1;
    wr_idx = idx;
    entryhi = hi;
    entrylo0 = l0;
    entrylo1 = l1;
    mask = m;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic probe(input logic [31:0] hi, input logic [31:0] e);
    probe_req = 1'b1;
    entryhi = hi;
    pq.push_back(e);
    tick;
    probe_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    asid = '0; wr_en = 0; wr_rand = 0; wr_idx = '0; mask = '0;
    entryhi = '0; entrylo0 = '0; entrylo1 = '0;
    wired_we = 0; wired_in = '0; probe_req = 0; flush = 0;
    lk_valid = '0; lk_vaddr = '0; lk_store = '0;
    #12;
    check("reset ctl", 64'({busy, random, probe_done, res_valid, res_miss}),
          64'({1'b1, 5'd31, 1'b0, 2'b00, 2'b00}));
    check("reset data", {probe_index, rd_hi}, 64'd0);
    check("reset paddr", 64'(res_paddr), 64'd0);

    resetn = 1'b1;
    look(0, 32'h0040_0000, 1'b0, MISS);
    n = 0;
    while (busy && n < 100) begin
      tick;
      lk_valid = '0;
      n++;
    end
    check("busy length", 64'(n), 64'd32);
    check("random after clear", 64'(random), 64'd31);

    tlbwi(5'd3, 32'h0040_0005, 32'h0000_049A, 32'h0000_04DE, 12'h000);
    asid = 8'd5;
    look(0, 32'h0040_0abc, 1'b0, ex(0, 0, 0, 3'd3, 32'h0001_2abc));
    look(1, 32'h0040_1abc, 1'b0, ex(0, 0, 0, 3'd3, 32'h0001_3abc));
    go;
    look(0, 32'h0040_0000, 1'b1, ex(0, 0, 1, 3'd3, 32'h0001_2000));
    look(1, 32'h0040_1000, 1'b1, ex(0, 0, 0, 3'd3, 32'h0001_3000));
    go;
    asid = 8'd6;
    look(0, 32'h0040_0abc, 1'b0, MISS);
    go;
    tlbwi(5'd3, 32'h0040_0005, 32'h0000_049B, 32'h0000_04DF, 12'h000);
    look(0, 32'h0040_0abc, 1'b0, ex(0, 0, 0, 3'd3, 32'h0001_2abc));
    go;

    tlbwi(5'd4, 32'h0080_0006, 32'h0000_0810, 32'h0000_0000, 12'h000);
    look(1, 32'h0080_0010, 1'b1, ex(0, 1, 0, 3'd2, 32'h0002_0010));
    go;

    tlbwi(5'd5, 32'h0040_0006, 32'h0000_101E, 32'h0000_111E, 12'h003);
    look(0, 32'h0040_6123, 1'b0, ex(0, 0, 0, 3'd3, 32'h0004_6123));
    look(1, 32'h0040_2123, 1'b0, ex(0, 0, 0, 3'd3, 32'h0004_2123));
    go;

    wired_we = 1'b1;
    wired_in = 5'd4;
    tick;
    wired_we = 1'b0;
    for (int i = 0; i < 28; i++) begin
      check("random sequence", 64'(random), 64'(31 - i));
      tick;
    end
    check("random wrap", 64'(random), 64'd31);

    n = 0;
    while (random != 5'd10 && n < 64) begin
      tick;
      n++;
    end
    check("random reaches 10", 64'(random), 64'd10);
    wr_rand = 1'b1;
    entryhi = 32'h00c0_0007;
    entrylo0 = 32'h0000_1553;
    entrylo1 = 32'h0000_1597;
    mask = 12'h000;
    tick;
    wr_en = 1'b1;
    wr_idx = 5'd12;
    entryhi = 32'h0240_0003;
    entrylo0 = '0;
    entrylo1 = '0;
    tick;
    wr_en = 1'b0;
    wr_rand = 1'b0;

    wr_idx = 5'd10;
    #1;
    check("tlbr hi 10", 64'(rd_hi), 64'h00c0_0007);
    check("tlbr lo 10", {rd_lo0, rd_lo1}, {32'h0000_1553, 32'h0000_1597});
    check("tlbr mask 10", 64'(rd_mask), 64'h0);
    wr_idx = 5'd12;
    #1;
    check("wr_en over wr_rand", 64'(rd_hi), 64'h0240_0003);
    wr_idx = 5'd9;
    #1;
    check("random slot untouched", 64'(rd_hi), 64'h0);
    wr_idx = 5'd5;
    #1;
    check("tlbr 16k", {rd_hi, 20'b0, rd_mask},
          {32'h0040_0006, 20'b0, 12'h003});
    check("tlbr 16k lo1", 64'(rd_lo1), 64'h0000_111E);

    asid = 8'd7;
    look(0, 32'h00c0_0123, 1'b0, ex(0, 0, 0, 3'd2, 32'h0005_5123));
    go;

    tlbwi(5'd2, 32'h0140_0009, 32'h0000_049A, 32'h0000_04DE, 12'h000);
    tlbwi(5'd7, 32'h0140_0009, 32'h0000_049A, 32'h0000_04DE, 12'h000);
    probe(32'h0140_0009, 32'h4000_0002);
    probe(32'h00c0_0007, 32'h0000_000a);
    probe(32'h00c0_0008, 32'h0000_000a);
    probe(32'h0040_0006, 32'h4000_0003);
    probe(32'h0200_0001, 32'h8000_0000);

    flush = 1'b1;
    tick;
    flush = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 5) begin
        wr_en = 1'b1;
        wr_idx = 5'd1;
        entryhi = 32'h0180_0009;
      end else if (n == 6) begin
        wr_en = 1'b1;
        wr_idx = 5'd20;
        entryhi = 32'h01c0_0009;
      end else begin
        wr_en = 1'b0;
      end
      tick;
      n++;
    end
    wr_en = 1'b0;
    check("flush busy length", 64'(n), 64'd32);
    probe(32'h0140_0009, 32'h8000_0000);
    probe(32'h0180_0009, 32'h0000_0001);
    probe(32'h01c0_0009, 32'h8000_0000);
    asid = 8'd5;
    look(1, 32'h0040_0abc, 1'b0, MISS);
    go;

    repeat (3) tick;
    check("lk0 drained", 64'(q0.size()), 64'd0);
    check("lk1 drained", 64'(q1.size()), 64'd0);
    check("probe drained", 64'(pq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tlb_pipe.md
Name: tlb_pipe

Overview:
Next-generation joint TLB for the MIPS core. It has PORTS independent lookup channels, each with a registered 1-cycle lookup (fetch, load/store, spare). It adds hardware random replacement (Random/Wired), a self-clearing invalidate FSM for reset and flush, and probe multi-hit detection. It sits between the CP0 register file and the I/D cache address paths.

Parameters:
ENTRIES, 32, number of TLB entries (power of 2, 4..64)
IDXBITS, 5, log2(ENTRIES)
PORTS, 2, number of lookup channels
ASIDBITS, 8, ASID width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
asid  in  ASIDBITS  current EntryHi.ASID used for all lookups
wr_en  in  1  TLBWI: write entry at wr_idx
wr_rand  in  1  TLBWR: write entry at current random
wr_idx  in  IDXBITS  index for TLBWI/TLBR
mask  in  12  PageMask[24:13]
entryhi  in  32  EntryHi
entrylo0  in  32  EntryLo0
entrylo1  in  32  EntryLo1
wired_we  in  1  write Wired register
wired_in  in  IDXBITS  new Wired value
random  out  IDXBITS  current Random register
rd_hi, rd_lo0, rd_lo1  out  32  TLBR data for wr_idx (combinational)
rd_mask  out  12  TLBR mask
probe_req  in  1  start TLBP using entryhi
probe_done  out  1  probe result valid (1-cycle pulse)
probe_index  out  32  bit31=miss, bit30=multi-hit, [IDXBITS-1:0]=index
flush  in  1  request invalidate-all
busy  out  1  invalidate FSM running
lk_valid  in  PORTS  lookup request per channel
lk_vaddr  in  PORTS*32  virtual address, channel k at [32k+31:32k]
lk_store  in  PORTS  request is a store
res_valid  out  PORTS  result valid
res_paddr  out  PORTS*32  physical address
res_cache  out  PORTS*3  C attribute
res_miss, res_invalid, res_modify  out  PORTS  exception flags

Behaviour:
- Reset (resetn low, async): all outputs 0 except random=ENTRIES-1 and busy=1. Wired=0. FSM enters CLEAR with ptr=0.
- Each entry holds mask, vpn2 (entryhi[31:13] & ~mask), G = lo0.G & lo1.G, asid, and per-page pfn (& ~mask), C, D, V. It also holds a present bit E that is not architecturally visible.
- FSM states:
  - IDLE: flush=1 -> CLEAR, ptr=0.
  - CLEAR: clear E[ptr] each cycle; at ptr=ENTRIES-1 -> IDLE.
  - ENTRIES cycles per clear. busy=1 in CLEAR.
  - A flush during CLEAR restarts ptr at 0.
- Write vs clear: a write during CLEAR to an index not yet cleared is lost. A write to an index already cleared is kept. wr_en sets E=1.
- Match condition: E & (vaddr[31:13]&~mask == vpn2&~mask) & (G | asid match).
- Odd/even select bit: vaddr[12+n], where mask = 2^n-1 in pairs. This gives bit 12 for mask 0x000, bit 14 for 0x003, and so on up to bit 24 for 0xFFF.
- Physical address: paddr = (pfn<<12 & ~(mask<<12)) | (vaddr & {mask,12'hfff}).
- Non-contiguous mask values give undefined translation.
- Lookup timing:
  - lk_valid[k] at cycle N gives res_valid[k]=1 at N+1, with results held until the next request.
  - res_valid deasserts when lk_valid was 0.
  - Lookup sees TLB state before any write in cycle N; the write is visible from N+1.
  - All channels are independent; there is no back-pressure.
- Flags:
  - miss = no match.
  - invalid = ~miss & ~V.
  - modify = ~miss & V & store & ~D.
  - paddr and cache are 0 on miss.
  - Multiple matches on a lookup are OR-merged, with undefined data.
- Probe: probe_req at N gives probe_done at N+1.
  - Index is the lowest matching index.
  - bit30 is set if more than one entry matches.
  - bit31 is set if no entry matches; the index is then 0.
  - A probe during CLEAR sees only entries with E=1.
- Random register:
  - Decrements every cycle.
  - When random==wired, or random<wired, the next value is ENTRIES-1.
  - wired_we loads Wired and forces random=ENTRIES-1 on the next cycle.
  - wr_rand writes at the random value sampled in that cycle.
  - wr_en and wr_rand in the same cycle: wr_en wins.
- TLBR reads: rd_hi = {vpn2, 5'b0 padding to ASID, asid zero-extended}. rd_lo0 and rd_lo1 = {6'b0, pfn, C, D, V, G}.

Decomposition:
- Shared package tlb_pkg: entry field bit positions (ENTRYHI_VPN2, ENTRYHI_ASID, ENTRYLO_PFN/C/D/V/G), PROBE_MISS_BIT=31, PROBE_MULTI_BIT=30, and FSM state encodings.
- One sub-module, tlb_match_port: combinational match/select/translate for one channel. It is instantiated PORTS times plus once for the probe, then registered in tlb_pipe.

Test Plan:
- Reset, then immediately present lk_vaddr=0x00400000 -> res_miss=1 with busy=1 for 32 cycles, then busy=0 and random=31.
- TLBWI idx=3, entryhi=0x00400000 (asid 5), lo0 pfn=0x12 V=1 D=0 C=3, lo1 pfn=0x13 V=1 D=1, mask=0. Lookup with asid=5:
  - vaddr 0x00400abc -> paddr 0x00012abc, cache=3.
  - vaddr 0x00401abc -> paddr 0x00013abc.
  - store to 0x00400000 -> res_modify=1.
- Same entry, asid=6, G=0 -> res_miss=1. Rewrite with G=1 in both lo -> hit.
- mask=0x003 (16K), vpn2 0x00400000 -> vaddr 0x00406123 selects the odd page, paddr = pfn1<<12 | 0x2123.
- wired=4: random sequence 31..4 then wraps to 31. TLBWR at random=10 writes entry 10. TLBR idx=10 returns the written fields.
- Two entries with the same VPN and asid at idx 2 and 7 -> probe_index=0x40000002. Flush -> probe after busy falls returns 0x80000000.
